// File: rtl/shift_rotate_pipe_if.sv
// Request/result bus of the shift/rotate pipeline.
// The master side drives requests and accepts results. The slave side is the pipeline.
interface shift_rotate_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_illegal
  );
endinterface

// File: rtl/shift_rotate_pipe.sv
// Shift/rotate unit behind a LAT-deep elastic pipeline.
// The result is computed from the request and captured in stage 0.
// The remaining stages carry it, and each stage has its own valid bit.
// Stages fill bubbles while downstream is stalled, and results leave in acceptance order.
module shift_rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_rotate_pipe_if.slave   io
);
  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic [WIDTH-1:0]   res;
  logic               res_illegal;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_sh;

  logic [LAT-1:0]     stg_valid;
  logic [LAT-1:0]     stg_zero;
  logic [LAT-1:0]     stg_ill;
  logic [WIDTH-1:0]   stg_data [LAT];

  logic [LAT-1:0]     adv;
  logic [LAT:0]       room;
  logic [LAT-1:0]     push;
  logic [WIDTH-1:0]   src_data [LAT];
  logic [LAT-1:0]     src_zero;
  logic [LAT-1:0]     src_ill;

  // Operation datapath. A rotate is a shift of the operand concatenated with itself.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    res         = '0;
    res_illegal = 1'b0;
    dbl         = {io.in_data, io.in_data};
    dbl_sh      = '0;
    case (io.in_op)
      OP_ROR: begin
        dbl_sh = dbl >> io.in_shamt;
        res    = dbl_sh[WIDTH-1:0];
      end
      OP_ROL: begin
        dbl_sh = dbl << io.in_shamt;
        res    = dbl_sh[2*WIDTH-1:WIDTH];
      end
      OP_SLL:  res = io.in_data << io.in_shamt;
      OP_SRL:  res = io.in_data >> io.in_shamt;
      OP_SRA:  res = $unsigned($signed(io.in_data) >>> io.in_shamt);
      default: res_illegal = 1'b1;
    endcase
  end

  // Back-pressure chain. A stage advances when the slot after it has room.
  // The slot after the last stage has room when out_ready is high.
  always_comb begin
    adv       = '0;
    room      = '0;
    room[LAT] = io.out_ready;
    for (int i = LAT - 1; i >= 0; i--) begin
      adv[i]  = stg_valid[i] && room[i+1];
      room[i] = !stg_valid[i] || adv[i];
    end
  end

  // in_ready depends only on state, out_ready and rst. It never depends on in_valid.
  assign io.in_ready = room[0] && !rst;

  // Load strobes and source values for each stage.
  always_comb begin
    push        = '0;
    src_zero    = '0;
    src_ill     = '0;
    push[0]     = io.in_valid && io.in_ready;
    src_data[0] = res;
    src_zero[0] = (res == '0);
    src_ill[0]  = res_illegal;
    for (int i = 1; i < LAT; i++) begin
      push[i]     = adv[i-1];
      src_data[i] = stg_data[i-1];
      src_zero[i] = stg_zero[i-1];
      src_ill[i]  = stg_ill[i-1];
    end
  end

  // Stage occupancy. Reset flushes every in-flight request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so all stages update from pre-edge values.
    if (rst) begin
      stg_valid <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (push[i])     stg_valid[i] <= 1'b1;
        else if (adv[i]) stg_valid[i] <= 1'b0;
      end
    end
  end

  // Stage payload. A stage captures its source value whenever it is loaded.
  always_ff @(posedge clk) begin
    // NOTE: payload registers have no reset. Outputs are gated by the valid bit, so stale contents never escape.
    for (int i = 0; i < LAT; i++) begin
      if (push[i]) begin
        stg_data[i] <= src_data[i];
        stg_zero[i] <= src_zero[i];
        stg_ill[i]  <= src_ill[i];
      end
    end
  end

  assign io.out_valid   = stg_valid[LAT-1];
  assign io.out_data    = stg_valid[LAT-1] ? stg_data[LAT-1] : '0;
  assign io.out_zero    = stg_valid[LAT-1] && stg_zero[LAT-1];
  assign io.out_illegal = stg_valid[LAT-1] && stg_ill[LAT-1];
endmodule

// File: doc/shift_rotate_pipe.md
SHIFT_ROTATE_PIPE -- requirements
Module: shift_rotate_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH SHALL default to 32 and set the data width; legal values are powers of two, 8 to 64.
REQ-003 Parameter LAT SHALL default to 2 and set pipeline latency in cycles; legal values are 1 to $clog2(WIDTH).
REQ-004 Derived constant SHW SHALL equal $clog2(WIDTH).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  request accepted this cycle when high together with in_valid.
REQ-009 in_data  input  WIDTH  operand.
REQ-010 in_shamt  input  SHW  shift/rotate amount.
REQ-011 in_op  input  3  operation select.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_data  output  WIDTH  result.
REQ-015 out_zero  output  1  high when out_data is all zeros.
REQ-016 out_illegal  output  1  high when the request carried an unsupported in_op.

Function
REQ-017 in_op encoding SHALL be: 000 ROR, 001 ROL, 010 SLL, 011 SRL, 100 SRA; 101/110/111 are illegal.
REQ-018 ROR/ROL SHALL rotate by in_shamt modulo WIDTH; bits leaving one end enter the other.
REQ-019 SLL/SRL SHALL zero-fill; SRA SHALL fill with in_data[WIDTH-1].
REQ-020 in_shamt = 0 SHALL pass in_data unchanged for every legal op.
REQ-021 Illegal op SHALL produce out_data = 0, out_zero = 1, out_illegal = 1, and use a pipeline slot like any other request.
REQ-022 Pipeline SHALL hold LAT register stages, each with its own valid bit; capacity is LAT requests.
REQ-023 A request accepted in cycle N SHALL appear on out_valid in cycle N+LAT when no stall occurs.
REQ-024 A stage SHALL advance when the next stage is empty or advances in the same cycle; the last stage advances when out_ready = 1.
REQ-025 in_ready SHALL equal (stage-1 empty) OR (stage 1 advances this cycle), with no combinational path from in_valid.
REQ-026 With out_ready held high, throughput SHALL be one result per cycle.
REQ-027 While out_valid = 1 and out_ready = 0, out_data, out_zero and out_illegal SHALL hold stable.
REQ-028 Results SHALL emerge in acceptance order; no request is dropped or duplicated.
REQ-029 Bubbles SHALL collapse: an empty stage is filled even while downstream stalls.
REQ-030 out_zero and out_illegal SHALL be registered alongside out_data in the same stage.
REQ-031 When out_valid = 0, out_data, out_zero and out_illegal SHALL be 0.

Reset
REQ-032 On rst = 1 at a clock edge, all stage valid bits, out_valid, out_data, out_zero and out_illegal SHALL become 0.
REQ-033 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-034 Reset mid-operation SHALL discard all in-flight requests; none emerge after reset.
REQ-035 A request presented in a cycle with rst = 1 SHALL NOT be accepted.

Verification (WIDTH=32, LAT=2)
REQ-036 ROR 0x80000001, shamt 1, accepted at N -> out_data 0xC0000000, out_valid 1 at N+2.
REQ-037 ROL 0x80000001, shamt 4 -> 0x00000018; SLL same -> 0x00000010.
REQ-038 SRA 0xF0000000, shamt 4 -> 0xFF000000; SRL same -> 0x0F000000; SRA 0x12345678, shamt 0 -> 0x12345678.
REQ-039 Stream 4 requests with out_ready = 0 for 3 cycles -> in_ready drops after 2 accepted, outputs hold stable, all 4 results arrive in order once out_ready = 1.
REQ-040 in_op 111, data 0xFFFFFFFF -> out_data 0, out_zero 1, out_illegal 1 after 2 cycles.
REQ-041 Assert rst with 2 requests in flight -> out_valid 0 the next cycle and no stale result ever appears.
